alu_sru_seq: RTL and testbench

- Control-side sequencer directly upstream of the ALU shift/rotate unit (SRU).
- Accepts a one-cycle request from the microcode together with the 7-bit SRU instruction field.
- Latches and holds the op fields, issues the active-low start pulse, and counts the SRU's shift acknowledgements.
- Signals done, or error on timeout, so the microcode can stop waiting before it reads port B.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_sru_seq_ctr.sv | 37 +++
 rtl/alu_sru_seq.sv | 103 ++++++++++
 tb/tb_alu_sru_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU shift/rotate unit: sequencer states and SRU op codes.
// Pure definitions; no logic, no latency, no flow control.
package alu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_FIN   = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    // {rotate, arithmetic, right}
    localparam logic [2:0] SHL     = 3'b000;
    localparam logic [2:0] SHR     = 3'b001;
    localparam logic [2:0] ILLEGAL = 3'b010;
    localparam logic [2:0] ASR     = 3'b011;
    localparam logic [2:0] ROL     = 3'b100;
    localparam logic [2:0] ROR     = 3'b101;
    localparam logic [2:0] RLA     = 3'b110;
    localparam logic [2:0] RRA     = 3'b111;

    // Arithmetic left shift has no meaning on the SRU.
    function automatic logic is_illegal(input logic [2:0] cls);
        return cls == ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_sru_seq_ctr.sv
// Clearable up-counter; hit_o flags that this increment lands exactly on cmp_i.
// Count updates one cycle after inc_i; hit_o is combinational; no backpressure.
module alu_sru_seq_ctr #(
    parameter int W = 5
) (
    input  logic         clk3,
    input  logic         nreset,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] cmp_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk3) begin
        if (nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare the post-increment value so the FSM can leave on the same edge.
    assign hit_o = inc_i && ((cnt_q + W'(1)) == cmp_i);

endmodule

// File: rtl/alu_sru_seq.sv
// Sequencer in front of the SRU: latches the op, pulses nstart, counts shift acks, reports done/err.
// go-to-done is 2 cycles for distance 0, else 2 + cycles to the last ack; go while busy is dropped.
module alu_sru_seq
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 20,
    parameter int DW      = 4
) (
    input  logic          clk3,
    input  logic          nreset,
    input  logic          go,
    input  logic [DW+2:0] ir_op,
    input  logic          shift_ack,
    output logic          nstart,
    output logic          op_rotate,
    output logic          op_arithmetic,
    output logic          op_right,
    output logic [DW-1:0] op_dist,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [2:0]    cls_q, cls_d;
    logic [DW-1:0] dist_q, dist_d;
    logic          cnt_clr;
    logic          in_shift;
    logic          sh_hit;
    logic          to_hit;

    assign cnt_clr  = (state_q == S_START);
    assign in_shift = (state_q == S_SHIFT);

    alu_sru_seq_ctr #(.W(DW + 1)) u_shift_ctr (
        .clk3   (clk3),
        .nreset (nreset),
        .clr_i  (cnt_clr),
        .inc_i  (in_shift && shift_ack),
        .cmp_i  ({1'b0, dist_q}),
        .hit_o  (sh_hit)
    );

    alu_sru_seq_ctr #(.W(TW)) u_timeout_ctr (
        .clk3   (clk3),
        .nreset (nreset),
        .clr_i  (cnt_clr),
        .inc_i  (in_shift),
        .cmp_i  (TW'(TIMEOUT)),
        .hit_o  (to_hit)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        dist_d  = dist_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    cls_d   = ir_op[DW+2:DW];
                    dist_d  = ir_op[DW-1:0];
                    state_d = is_illegal(ir_op[DW+2:DW]) ? S_FAULT : S_START;
                end
            end
            S_START: state_d = (dist_q == '0) ? S_FIN : S_SHIFT;
            S_SHIFT: begin
                // Final ack takes priority over a coincident timeout.
                if (sh_hit) begin
                    state_d = S_FIN;
                end else if (to_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk3) begin
        if (nreset) begin
            state_q <= S_IDLE;
            cls_q   <= '0;
            dist_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            dist_q  <= dist_d;
        end
    end

    assign nstart        = (state_q != S_START);
    assign busy          = (state_q == S_START) || (state_q == S_SHIFT);
    assign done          = (state_q == S_FIN);
    assign err           = (state_q == S_FAULT);
    assign op_rotate     = cls_q[2];
    assign op_arithmetic = cls_q[1];
    assign op_right      = cls_q[0];
    assign op_dist       = dist_q;

endmodule

// File: tb/tb_alu_sru_seq.sv
// Bench for alu_sru_seq: directed vector table, reset-mid-shift sequence, random ops vs a transaction model.
module tb_alu_sru_seq;
    import alu_pkg::*;

    localparam int TIMEOUT = 20;
    localparam int DW      = 4;
    localparam int NCYC    = TIMEOUT + 4;

    logic       clk3 = 1'b0;
    logic       nreset;
    logic       go;
    logic [6:0] ir_op;
    logic       shift_ack;
    logic       nstart;
    logic       op_rotate;
    logic       op_arithmetic;
    logic       op_right;
    logic [3:0] op_dist;
    logic       busy;
    logic       done;
    logic       err;

    alu_sru_seq #(.TIMEOUT(TIMEOUT), .DW(DW)) dut (
        .clk3          (clk3),
        .nreset        (nreset),
        .go            (go),
        .ir_op         (ir_op),
        .shift_ack     (shift_ack),
        .nstart        (nstart),
        .op_rotate     (op_rotate),
        .op_arithmetic (op_arithmetic),
        .op_right      (op_right),
        .op_dist       (op_dist),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk3 = ~clk3;

    int errors = 0;
    int checks = 0;
    bit ack_at [0:NCYC];

    typedef struct {
        logic [6:0] op;
        int         first;
        int         gap;
        int         nack;
        bit         busy_go;
        int         exp_end;
        bit         exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    task automatic set_sched(input int first, input int gap, input int nack);
        for (int c = 0; c <= NCYC; c++) ack_at[c] = 1'b0;
        for (int k = 0; k < nack; k++) begin
            if (first + k * gap <= NCYC) ack_at[first + k * gap] = 1'b1;
        end
    endtask

    // Cycle 1 follows the edge that accepts go; the SHIFT window is cycles 2 .. TIMEOUT+1.
    function automatic void model(input logic [6:0] op, output int end_c, output bit is_err);
        int cnt;
        cnt = 0;
        if (op[6:4] == ILLEGAL) begin
            end_c = 1; is_err = 1'b1;
        end else if (op[3:0] == 4'd0) begin
            end_c = 2; is_err = 1'b0;
        end else begin
            end_c = 2 + TIMEOUT; is_err = 1'b1;
            for (int j = 0; j < TIMEOUT; j++) begin
                if (ack_at[2 + j]) begin
                    cnt++;
                    if (cnt == int'(op[3:0])) begin
                        end_c = 3 + j; is_err = 1'b0;
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic run_txn(input string nm, input logic [6:0] op, input bit busy_go,
                           input int exp_end, input bit exp_err);
        int n_nst = 0, f_nst = -1, n_done = 0, f_done = -1;
        int n_err = 0, f_err = -1, n_busy = 0, op_bad = 0;
        bit legal;
        legal = (op[6:4] != ILLEGAL);
        go = 1'b1; ir_op = op; shift_ack = 1'b0;
        @(posedge clk3); #1;
        go = 1'b0;
        for (int c = 1; c <= NCYC; c++) begin
            if (!nstart) begin n_nst++; if (f_nst < 0) f_nst = c; end
            if (done)    begin n_done++; if (f_done < 0) f_done = c; end
            if (err)     begin n_err++; if (f_err < 0) f_err = c; end
            if (busy)    n_busy++;
            if ({op_rotate, op_arithmetic, op_right, op_dist} !== op) op_bad++;
            shift_ack = ack_at[c];
            go = busy_go && (c == 3);
            ir_op = go ? ~op : 7'($urandom);
            @(posedge clk3); #1;
        end
        shift_ack = 1'b0; go = 1'b0;
        chk({nm, "/nstart_cnt"}, n_nst, legal ? 1 : 0);
        chk({nm, "/nstart_cyc"}, f_nst, legal ? 1 : -1);
        chk({nm, "/done_cnt"},   n_done, exp_err ? 0 : 1);
        chk({nm, "/done_cyc"},   f_done, exp_err ? -1 : exp_end);
        chk({nm, "/err_cnt"},    n_err, exp_err ? 1 : 0);
        chk({nm, "/err_cyc"},    f_err, exp_err ? exp_end : -1);
        chk({nm, "/busy_cyc"},   n_busy, legal ? exp_end - 1 : 0);
        chk({nm, "/op_hold"},    op_bad, 0);
    endtask

    initial begin
        int n_done, n_err, e_end, pct;
        bit e_err, bg;
        logic [6:0] rop;

        //            op          first gap nack bgo end err
        vecs[0] = '{7'b000_0101,  2,   4,  5,   1,  19, 0};
        vecs[1] = '{7'b101_0000,  0,   0,  0,   0,   2, 0};
        vecs[2] = '{7'b010_0011,  0,   0,  0,   0,   1, 1};
        vecs[3] = '{7'b111_1111,  2,   4,  3,   1,  22, 1};
        vecs[4] = '{7'b100_0001, 21,   1,  1,   0,  22, 0};
        vecs[5] = '{7'b100_0001, 22,   1,  1,   0,  22, 1};
        vecs[6] = '{7'b001_0010,  1,   1,  3,   0,   4, 0};
        vecs[7] = '{7'b011_1111,  2,   1, 15,   1,  17, 0};

        nreset = 1'b1; go = 1'b0; shift_ack = 1'b0; ir_op = '0;
        repeat (2) @(posedge clk3);
        #1;
        chk("rst/nstart", nstart, 1);
        chk("rst/busy",   busy, 0);
        chk("rst/done",   done, 0);
        chk("rst/err",    err, 0);
        chk("rst/op",     {op_rotate, op_arithmetic, op_right, op_dist}, 0);
        nreset = 1'b0;

        foreach (vecs[i]) begin
            set_sched(vecs[i].first, vecs[i].gap, vecs[i].nack);
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].busy_go,
                    vecs[i].exp_end, vecs[i].exp_err);
        end

        // Reset in the middle of SHIFT after three acks.
        go = 1'b1; ir_op = 7'b000_1000;
        @(posedge clk3); #1;
        go = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            shift_ack = (c >= 2 && c <= 4);
            @(posedge clk3); #1;
        end
        shift_ack = 1'b0;
        chk("midrst/busy_before", busy, 1);
        nreset = 1'b1;
        @(posedge clk3); #1;
        nreset = 1'b0;
        chk("midrst/busy",   busy, 0);
        chk("midrst/nstart", nstart, 1);
        chk("midrst/dist",   op_dist, 0);
        chk("midrst/done",   done, 0);
        chk("midrst/err",    err, 0);
        n_done = 0; n_err = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (done) n_done++;
            if (err)  n_err++;
            shift_ack = (c < 8);
            @(posedge clk3); #1;
        end
        shift_ack = 1'b0;
        chk("midrst/late_done", n_done, 0);
        chk("midrst/late_err",  n_err, 0);

        for (int t = 0; t < 40; t++) begin
            rop = 7'($urandom);
            pct = $urandom_range(0, 100);
            for (int c = 0; c <= NCYC; c++) ack_at[c] = ($urandom_range(0, 99) < pct);
            model(rop, e_end, e_err);
            bg = (rop[6:4] != ILLEGAL) && (e_end >= 5) && ($urandom_range(0, 1) == 1);
            run_txn($sformatf("rnd%0d", t), rop, bg, e_end, e_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
